// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM pair.
// Speed codes are 8-bit unsigned with 128 as the stop point; step codes are
// 3-bit offsets around STEP_ZERO (4), giving a per-frame nudge of -4..+3.
package servo_pkg;

  localparam int          SPEED_W    = 8;
  localparam int          STEP_W     = 3;
  localparam logic [7:0]  SPEED_STOP = 8'd128;
  localparam logic [2:0]  STEP_ZERO  = 3'd4;

  // Clamp a 10-bit signed intermediate into the 0..255 speed range.
  function automatic logic [7:0] sat8(input logic signed [9:0] v);
    logic [7:0] r;
    if (v < 10'sd0) begin
      r = 8'd0;
    end else if (v > 10'sd255) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target register, slew-limited applied speed, per-frame pulse width latch, PWM compare.
// Latency: a target change reaches the pulse at the next frame start; PWM is registered (one clk behind frame_count).
// Backpressure: none; commands are accepted every clk, steps only on the frame-start clk.
// Ports: clk/rst_n; frame_start, frame_count from the shared timebase;
//   speed_we/speed/step command inputs; pwm output; settled (applied == target).
module servo_channel
  import servo_pkg::*;
#(
  parameter int PULSE_BASE_US = 988,
  parameter int PULSE_LSB_US  = 4,
  parameter int RAMP_STEP     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [15:0]        frame_count,
  input  logic               speed_we,
  input  logic [SPEED_W-1:0] speed,
  input  logic [STEP_W-1:0]  step,
  output logic               pwm,
  output logic               settled
);

  localparam logic signed [9:0] RAMP_S = 10'(RAMP_STEP);

  logic [SPEED_W-1:0] target_q;
  logic [SPEED_W-1:0] applied_q;
  logic [15:0]        width_q;
  logic               pwm_q;

  logic [SPEED_W-1:0] target_nxt;
  logic [SPEED_W-1:0] applied_nxt;
  logic [15:0]        width_nxt;
  logic [15:0]        width_cmp;
  logic signed [9:0]  diff;
  logic signed [9:0]  step_sum;

  always_comb begin
    diff     = $signed({2'b00, target_q}) - $signed({2'b00, applied_q});
    step_sum = $signed({2'b00, target_q}) + $signed({7'b0, step})
             - $signed({7'b0, STEP_ZERO});

    // Ramp uses the target as it stands before this clk's update, so a
    // write landing on the frame-start clk waits for the following frame.
    applied_nxt = target_q;
    if (RAMP_STEP != 0) begin
      if (diff > RAMP_S) begin
        applied_nxt = sat8($signed({2'b00, applied_q}) + RAMP_S);
      end else if (diff < -RAMP_S) begin
        applied_nxt = sat8($signed({2'b00, applied_q}) - RAMP_S);
      end
    end

    // Absolute write wins over a step on the same clk.
    target_nxt = target_q;
    if (speed_we) begin
      target_nxt = speed;
    end else if (frame_start) begin
      target_nxt = sat8(step_sum);
    end

    width_nxt = 16'(PULSE_BASE_US) + 16'({8'b0, applied_nxt}) * 16'(PULSE_LSB_US);

    // On the frame-start clk the fresh width governs count 0 onward.
    width_cmp = frame_start ? width_nxt : width_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q  <= SPEED_STOP;
      applied_q <= SPEED_STOP;
      width_q   <= 16'(PULSE_BASE_US) + 16'({8'b0, SPEED_STOP}) * 16'(PULSE_LSB_US);
      pwm_q     <= 1'b0;
    end else begin
      target_q <= target_nxt;
      if (frame_start) begin
        applied_q <= applied_nxt;
        width_q   <= width_nxt;
      end
      pwm_q <= (frame_count < width_cmp);
    end
  end

  assign pwm     = pwm_q;
  assign settled = (applied_q == target_q);

endmodule

// File: rtl/servo_pwm_pair.sv
// Two slew-limited 50 Hz hobby-servo PWM outputs sharing one microsecond timebase and frame counter.
// Latency: absolute write to first affected pulse is at most one frame plus one clk.
// Backpressure: none; inputs are sampled every clk, outputs are free-running.
// Ports: clk, rst_n; per-servo speed_we/speed/step; PWM_OUT_0/1; frame_strobe (first clk of
//   each frame); settled[n] = servo n applied speed equals its target.
module servo_pwm_pair
  import servo_pkg::*;
#(
  parameter int CLK_HZ        = 12_000_000,
  parameter int FRAME_US      = 20000,
  parameter int PULSE_BASE_US = 988,
  parameter int PULSE_LSB_US  = 4,
  parameter int RAMP_STEP     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               servo_0_speed_we,
  input  logic [SPEED_W-1:0] servo_0_speed,
  input  logic [STEP_W-1:0]  servo_0_step,
  input  logic               servo_1_speed_we,
  input  logic [SPEED_W-1:0] servo_1_speed,
  input  logic [STEP_W-1:0]  servo_1_step,
  output logic               PWM_OUT_0,
  output logic               PWM_OUT_1,
  output logic               frame_strobe,
  output logic [1:0]         settled
);

  localparam int DIV   = CLK_HZ / 1_000_000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [15:0]      frame_q;
  logic             start_q;
  logic             us_tick;
  logic             frame_start;
  logic             settled_0;
  logic             settled_1;

  assign us_tick = (pre_q == PRE_W'(DIV - 1));

  // start_q is preset in reset so the first clk after release is a frame
  // start; gating with rst_n keeps the strobe low while reset is held.
  assign frame_start  = rst_n & start_q;
  assign frame_strobe = frame_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      frame_q <= '0;
      start_q <= 1'b1;
    end else begin
      pre_q   <= us_tick ? '0 : pre_q + 1'b1;
      start_q <= 1'b0;
      if (us_tick) begin
        if (frame_q == 16'(FRAME_US - 1)) begin
          frame_q <= '0;
          start_q <= 1'b1;
        end else begin
          frame_q <= frame_q + 16'd1;
        end
      end
    end
  end

  servo_channel #(
    .PULSE_BASE_US (PULSE_BASE_US),
    .PULSE_LSB_US  (PULSE_LSB_US),
    .RAMP_STEP     (RAMP_STEP)
  ) u_ch0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_count (frame_q),
    .speed_we    (servo_0_speed_we),
    .speed       (servo_0_speed),
    .step        (servo_0_step),
    .pwm         (PWM_OUT_0),
    .settled     (settled_0)
  );

  servo_channel #(
    .PULSE_BASE_US (PULSE_BASE_US),
    .PULSE_LSB_US  (PULSE_LSB_US),
    .RAMP_STEP     (RAMP_STEP)
  ) u_ch1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_count (frame_q),
    .speed_we    (servo_1_speed_we),
    .speed       (servo_1_speed),
    .step        (servo_1_step),
    .pwm         (PWM_OUT_1),
    .settled     (settled_1)
  );

  assign settled = {settled_1, settled_0};

endmodule

// File: tb/tb_servo_pwm_pair.sv
// Bench for servo_pwm_pair: one instance with ramp limit 8, one unlimited, driven in parallel.
// Scaled timebase: 1 us per clk, 300 us frames, width = 10 + applied speed.
module tb_servo_pwm_pair;

  localparam int FRAME = 300;
  localparam int BASE  = 10;
  localparam int LSB   = 1;
  localparam int RAMP  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we0, we1;
  logic [7:0] spd0, spd1;
  logic [2:0] st0, st1;

  logic       m_pwm0, m_pwm1, m_strobe;
  logic [1:0] m_settled;
  logic       n_pwm0, n_pwm1, n_strobe;
  logic [1:0] n_settled;

  always #5 clk = ~clk;

  servo_pwm_pair #(
    .CLK_HZ(1_000_000), .FRAME_US(FRAME), .PULSE_BASE_US(BASE),
    .PULSE_LSB_US(LSB), .RAMP_STEP(RAMP)
  ) dut_m (
    .clk(clk), .rst_n(rst_n),
    .servo_0_speed_we(we0), .servo_0_speed(spd0), .servo_0_step(st0),
    .servo_1_speed_we(we1), .servo_1_speed(spd1), .servo_1_step(st1),
    .PWM_OUT_0(m_pwm0), .PWM_OUT_1(m_pwm1),
    .frame_strobe(m_strobe), .settled(m_settled)
  );

  servo_pwm_pair #(
    .CLK_HZ(1_000_000), .FRAME_US(FRAME), .PULSE_BASE_US(BASE),
    .PULSE_LSB_US(LSB), .RAMP_STEP(0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n),
    .servo_0_speed_we(we0), .servo_0_speed(spd0), .servo_0_step(st0),
    .servo_1_speed_we(we1), .servo_1_speed(spd1), .servo_1_step(st1),
    .PWM_OUT_0(n_pwm0), .PWM_OUT_1(n_pwm1),
    .frame_strobe(n_strobe), .settled(n_settled)
  );

  typedef struct packed {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] nw0;
    logic [15:0] nw1;
    logic [1:0]  sm;
    logic [1:0]  sn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: targets and applied speeds for the ramped (m) and unlimited (n) instances.
  int mt[2], ma[2], nt[2], na[2];

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp255(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int ramp_to(input int a, input int t, input int r);
    if (r == 0) return t;
    if (t - a > r) return a + r;
    if (a - t > r) return a - r;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mt[i] = 128; ma[i] = 128; nt[i] = 128; na[i] = 128;
    end
  endtask

  task automatic model_write(input logic w0, input logic w1);
    if (w0) begin mt[0] = spd0; nt[0] = spd0; end
    if (w1) begin mt[1] = spd1; nt[1] = spd1; end
  endtask

  // Frame-start update: ramp from the pre-update target, then write or step the target.
  task automatic model_frame_start(input logic w0, input logic w1);
    int s[2];
    s[0] = st0; s[1] = st1;
    for (int i = 0; i < 2; i++) begin
      ma[i] = ramp_to(ma[i], mt[i], RAMP);
      na[i] = ramp_to(na[i], nt[i], 0);
      mt[i] = clamp255(mt[i] + s[i] - 4);
      nt[i] = clamp255(nt[i] + s[i] - 4);
    end
    model_write(w0, w1);
  endtask

  // Called at the negedge of a frame-start clk; returns at the negedge of the next one.
  // Optional write pulse of one clk at cycle wr_at of the frame (0 = the frame-start clk).
  task automatic measure_frame(input int wr_at, input logic pw0, input logic pw1);
    exp_t e;
    int   cnt[4];
    int   strobes;
    cnt = '{0, 0, 0, 0};
    strobes = 0;
    if (wr_at == 0) model_frame_start(pw0, pw1);
    else begin
      model_frame_start(1'b0, 1'b0);
      model_write(pw0, pw1);
    end
    e.w0  = 16'(BASE + LSB * ma[0]);
    e.w1  = 16'(BASE + LSB * ma[1]);
    e.nw0 = 16'(BASE + LSB * na[0]);
    e.nw1 = 16'(BASE + LSB * na[1]);
    e.sm  = {ma[1] == mt[1], ma[0] == mt[0]};
    e.sn  = {na[1] == nt[1], na[0] == nt[0]};
    q.push_back(e);
    for (int k = 0; k < FRAME; k++) begin
      we0 = (k == wr_at) && pw0;
      we1 = (k == wr_at) && pw1;
      @(negedge clk);
      cnt[0] += int'(m_pwm0);
      cnt[1] += int'(m_pwm1);
      cnt[2] += int'(n_pwm0);
      cnt[3] += int'(n_pwm1);
      strobes += int'(m_strobe);
    end
    we0 = 1'b0;
    we1 = 1'b0;
    e = q.pop_front();
    check("m_width0", cnt[0], int'(e.w0));
    check("m_width1", cnt[1], int'(e.w1));
    check("n_width0", cnt[2], int'(e.nw0));
    check("n_width1", cnt[3], int'(e.nw1));
    check("m_settled", int'(m_settled), int'(e.sm));
    check("n_settled", int'(n_settled), int'(e.sn));
    check("strobes_per_frame", strobes, 1);
    check("strobe_at_wrap", int'(n_strobe), 1);
  endtask

  // Reset asserted partway through a pulse of the unlimited instance's servo 0.
  task automatic abort_frame(input int at);
    model_frame_start(1'b0, 1'b0);
    for (int k = 0; k < at; k++) @(negedge clk);
    check("pwm_high_before_reset", int'(n_pwm0), (at <= BASE + LSB * na[0]) ? 1 : 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_m_pwm", int'({m_pwm1, m_pwm0}), 0);
    check("rst_mid_n_pwm", int'({n_pwm1, n_pwm0}), 0);
    check("rst_mid_settled", int'({m_settled, n_settled}), 15);
    check("rst_mid_strobe", int'({m_strobe, n_strobe}), 0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    check("strobe_after_release2", int'(m_strobe), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0;
    spd0 = 8'd128; spd1 = 8'd128;
    st0 = 3'd4; st1 = 3'd4;

    // Reset held for 10 clks.
    repeat (10) @(negedge clk);
    check("rst_m_pwm", int'({m_pwm1, m_pwm0}), 0);
    check("rst_n_pwm", int'({n_pwm1, n_pwm0}), 0);
    check("rst_m_settled", int'(m_settled), 3);
    check("rst_n_settled", int'(n_settled), 3);
    check("rst_strobe", int'(m_strobe), 0);
    model_reset();
    rst_n = 1'b1;
    #1;
    check("strobe_after_release", int'(m_strobe), 1);
    measure_frame(0, 1'b0, 1'b0);

    // Ramp 128 -> 160 on servo 0, written on a frame-start clk.
    spd0 = 8'd160;
    measure_frame(0, 1'b1, 1'b0);
    repeat (4) measure_frame(0, 1'b0, 1'b0);

    // Full-scale write on servo 1; unlimited instance jumps, ramped one walks.
    spd1 = 8'd255;
    measure_frame(0, 1'b0, 1'b1);
    repeat (2) measure_frame(0, 1'b0, 1'b0);

    // Step mode: upward saturation at 255.
    spd0 = 8'd253;
    measure_frame(0, 1'b1, 1'b0);
    st0 = 3'd7;
    repeat (3) measure_frame(0, 1'b0, 1'b0);

    // Step mode: downward saturation at 0.
    st0 = 3'd4;
    spd0 = 8'd2;
    measure_frame(0, 1'b1, 1'b0);
    st0 = 3'd0;
    repeat (3) measure_frame(0, 1'b0, 1'b0);
    st0 = 3'd4;

    // Write and step together on the frame-start clk: write wins.
    st1 = 3'd7;
    spd1 = 8'd100;
    measure_frame(0, 1'b0, 1'b1);
    st1 = 3'd4;
    measure_frame(0, 1'b0, 1'b0);

    // Mid-frame write must not disturb the pulse in progress.
    spd0 = 8'd200;
    measure_frame(40, 1'b1, 1'b0);
    measure_frame(0, 1'b0, 1'b0);

    // Reset partway through a long pulse, then a clean frame from stop.
    abort_frame(70);
    measure_frame(0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
